// File: rtl/vga_timing_if.sv
// ============================================================================
// Module  : vga_timing_if
// Purpose : Timing outputs of vga_timing_gen toward a renderer/display sink.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_timing_if #(
    parameter int X_COORD_WIDTH = 10,
    parameter int Y_COORD_WIDTH = 10
);
    logic [X_COORD_WIDTH-1:0] x_px;
    logic [Y_COORD_WIDTH-1:0] y_px;
    logic                     activevideo;
    logic                     line_start;
    logic                     frame_start;
    logic [15:0]              frame_count;
    logic                     hsync_d;
    logic                     vsync_d;
    logic                     active_d;

    modport master (
        output x_px, y_px, activevideo, line_start, frame_start,
        output frame_count, hsync_d, vsync_d, active_d
    );

    modport slave (
        input x_px, y_px, activevideo, line_start, frame_start,
        input frame_count, hsync_d, vsync_d, active_d
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Purpose : VGA raster counters, per-axis porch/sync phase FSMs and delayed syncs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 128,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 9,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 28,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE_DELAY = 2
) (
    input  wire logic px_clk,
    input  wire logic reset,
    vga_timing_if.master tmg
);
    localparam int H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_COORD_WIDTH = $clog2(H_TOTAL);
    localparam int Y_COORD_WIDTH = $clog2(V_TOTAL);

    localparam logic [1:0] c_ph_active = 2'd0;
    localparam logic [1:0] c_ph_fp     = 2'd1;
    localparam logic [1:0] c_ph_sync   = 2'd2;
    localparam logic [1:0] c_ph_bp     = 2'd3;

    // Last index of each phase on each axis
    localparam logic [X_COORD_WIDTH-1:0] c_h_end_act  = X_COORD_WIDTH'(H_ACTIVE - 1);
    localparam logic [X_COORD_WIDTH-1:0] c_h_end_fp   = X_COORD_WIDTH'(H_ACTIVE + H_FP - 1);
    localparam logic [X_COORD_WIDTH-1:0] c_h_end_sync = X_COORD_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [X_COORD_WIDTH-1:0] c_h_end_bp   = X_COORD_WIDTH'(H_TOTAL - 1);
    localparam logic [Y_COORD_WIDTH-1:0] c_v_end_act  = Y_COORD_WIDTH'(V_ACTIVE - 1);
    localparam logic [Y_COORD_WIDTH-1:0] c_v_end_fp   = Y_COORD_WIDTH'(V_ACTIVE + V_FP - 1);
    localparam logic [Y_COORD_WIDTH-1:0] c_v_end_sync = Y_COORD_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [Y_COORD_WIDTH-1:0] c_v_end_bp   = Y_COORD_WIDTH'(V_TOTAL - 1);

    // Delay-stage bit order: {hsync, vsync, active}
    localparam logic [2:0] c_inactive = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};

    generate
        if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 ||
            V_BP == 0 || PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_params
            $error("vga_timing_gen: zero porch/sync width or PIPE_DELAY outside 1..8");
        end
    endgenerate

    logic [X_COORD_WIDTH-1:0]  h_cnt_q, h_cnt_d;
    logic [Y_COORD_WIDTH-1:0]  v_cnt_q, v_cnt_d;
    logic [1:0]                hph_q, hph_d;
    logic [1:0]                vph_q, vph_d;
    logic [15:0]               frame_count_q, frame_count_d;
    logic                      act_q, act_d;
    logic                      line_start_q, line_start_d;
    logic                      frame_start_q, frame_start_d;
    logic                      hs_q, hs_d;
    logic                      vs_q, vs_d;
    logic [PIPE_DELAY-1:0][2:0] dly_q, dly_d;
    logic                      h_wrap;
    logic                      v_wrap;

    // State register
    always_ff @(posedge px_clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hph_q         <= c_ph_active;
            vph_q         <= c_ph_active;
            frame_count_q <= '0;
            act_q         <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
            hs_q          <= ~H_SYNC_POL;
            vs_q          <= ~V_SYNC_POL;
            dly_q         <= {PIPE_DELAY{c_inactive}};
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hph_q         <= hph_d;
            vph_q         <= vph_d;
            frame_count_q <= frame_count_d;
            act_q         <= act_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            dly_q         <= dly_d;
        end
    end

    // Next state: counters and phase FSMs
    always_comb begin
        h_wrap  = (h_cnt_q == c_h_end_bp);
        v_wrap  = h_wrap && (v_cnt_q == c_v_end_bp);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + X_COORD_WIDTH'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + Y_COORD_WIDTH'(1);
        end
        frame_count_d = v_wrap ? frame_count_q + 16'd1 : frame_count_q;

        hph_d = hph_q;
        case (hph_q)
            c_ph_active: if (h_cnt_q == c_h_end_act)  hph_d = c_ph_fp;
            c_ph_fp:     if (h_cnt_q == c_h_end_fp)   hph_d = c_ph_sync;
            c_ph_sync:   if (h_cnt_q == c_h_end_sync) hph_d = c_ph_bp;
            default:     if (h_wrap)                  hph_d = c_ph_active;
        endcase

        // The vertical axis only moves on the line wrap
        vph_d = vph_q;
        if (h_wrap) begin
            case (vph_q)
                c_ph_active: if (v_cnt_q == c_v_end_act)  vph_d = c_ph_fp;
                c_ph_fp:     if (v_cnt_q == c_v_end_fp)   vph_d = c_ph_sync;
                c_ph_sync:   if (v_cnt_q == c_v_end_sync) vph_d = c_ph_bp;
                default:     if (v_wrap)                  vph_d = c_ph_active;
            endcase
        end
    end

    // Outputs are decoded from next state so they line up with the counters
    always_comb begin
        act_d         = (hph_d == c_ph_active) && (vph_d == c_ph_active);
        line_start_d  = (h_cnt_d == '0);
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
        hs_d          = (hph_d == c_ph_sync) ? H_SYNC_POL : ~H_SYNC_POL;
        vs_d          = (vph_d == c_ph_sync) ? V_SYNC_POL : ~V_SYNC_POL;

        dly_d    = dly_q;
        dly_d[0] = {hs_q, vs_q, act_q};
        for (int i = 1; i < PIPE_DELAY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    assign tmg.x_px        = h_cnt_q;
    assign tmg.y_px        = v_cnt_q;
    assign tmg.activevideo = act_q;
    assign tmg.line_start  = line_start_q;
    assign tmg.frame_start = frame_start_q;
    assign tmg.frame_count = frame_count_q;
    assign tmg.hsync_d     = dly_q[PIPE_DELAY-1][2];
    assign tmg.vsync_d     = dly_q[PIPE_DELAY-1][1];
    assign tmg.active_d    = dly_q[PIPE_DELAY-1][0];

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 24, horizontal front porch in pixels
- H_SYNC, 40, horizontal sync width in pixels
- H_BP, 128, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines
- V_FP, 9, vertical front porch in lines
- V_SYNC, 3, vertical sync width in lines
- V_BP, 28, vertical back porch in lines
- H_SYNC_POL, 0, hsync asserted level
- V_SYNC_POL, 0, vsync asserted level
- PIPE_DELAY, 2, downstream render latency in clocks, range 1..8
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- px_clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high reset
- x_px  out  X_COORD_WIDTH  current horizontal count
- y_px  out  Y_COORD_WIDTH  current vertical count
- activevideo  out  1  high while x_px < H_ACTIVE and y_px < V_ACTIVE
- line_start  out  1  one-cycle pulse when x_px == 0
- frame_start  out  1  one-cycle pulse when x_px == 0 and y_px == 0
- frame_count  out  16  count of completed frames, wraps
- hsync_d  out  1  hsync delayed by PIPE_DELAY
- vsync_d  out  1  vsync delayed by PIPE_DELAY
- active_d  out  1  activevideo delayed by PIPE_DELAY
REQ-003 SHALL derive the width parameters as follows: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (832 at defaults); V_TOTAL defined the same way from the V_* parameters (520 at defaults); X_COORD_WIDTH = $clog2(H_TOTAL); Y_COORD_WIDTH = $clog2(V_TOTAL).

Function
REQ-004 SHALL keep h_cnt in 0..H_TOTAL-1, incrementing every clock and wrapping to 0 after H_TOTAL-1.
REQ-005 SHALL increment v_cnt only on the clock where h_cnt wraps, wrapping from V_TOTAL-1 to 0; h_cnt and v_cnt wrapping on the same clock SHALL yield (0,0).
REQ-006 SHALL run per-axis phase FSMs ACTIVE->FP->SYNC->BP->ACTIVE, advancing when the axis counter reaches the phase's last index (H: 639, 663, 703, 831 at defaults).
REQ-007 SHALL register every output; x_px/y_px, activevideo, line_start and frame_start SHALL all describe the same (h_cnt,v_cnt) in the same cycle.
REQ-008 SHALL drive internal hsync = H_SYNC_POL while H phase == SYNC (h in 664..703), else ~H_SYNC_POL; vsync uses the V phase the same way (v in 489..491).
REQ-009 SHALL delay hsync, vsync and activevideo through a PIPE_DELAY-stage shift register to produce hsync_d, vsync_d and active_d, so they align with pixel data from a PIPE_DELAY-latency renderer.
REQ-010 SHALL increment frame_count on the clock where (h_cnt,v_cnt) goes from (H_TOTAL-1,V_TOTAL-1) to (0,0), wrapping from 0xFFFF to 0.
REQ-011 SHALL reject any parameter set with a zero porch or sync width, or PIPE_DELAY outside 1..8, by raising a $error at elaboration (simulation only).

Reset
REQ-012 SHALL, on the first clock after reset is sampled high, drive h_cnt=v_cnt=0, frame_count=0, both FSMs in ACTIVE, x_px=0, y_px=0, activevideo=1, line_start=1 and frame_start=1.
REQ-013 SHALL fill every delay stage with inactive levels during reset (sync = ~polarity, active = 0), so hsync_d=vsync_d=1 and active_d=0 at defaults until the real values propagate.
REQ-014 SHALL restart from (0,0) when reset is asserted mid-frame, with no partial line or extra frame_count increment.

Verification
REQ-015 Release reset, run 832 clocks -> x_px steps 0..831, then 0 with y_px=1; line_start high exactly at x_px=0.
REQ-016 Check hsync timing -> internal hsync low exactly at x_px 664..703; hsync_d low exactly 2 clocks later; active_d equals activevideo from 2 clocks earlier.
REQ-017 Run a full frame (832*520 = 432640 clocks) -> vsync low on lines 489..491 only; at (831,519)->(0,0) frame_start pulses and frame_count goes 0->1.
REQ-018 Preload frame_count to 0xFFFF (force), complete a frame -> frame_count=0x0000, no X on any output.
REQ-019 Assert reset at (300,200) for 3 clocks -> the clock after release shows (0,0), frame_count=0, and the delayed outputs hold inactive levels for 2 clocks.
REQ-020 Set PIPE_DELAY=1 and PIPE_DELAY=8 -> hsync_d/vsync_d/active_d lag by exactly 1 and 8 clocks, respectively.
